// File: rtl/light_display_pkg.sv
// rtl/light_display_pkg.sv - shared mode encodings and active-high 7-segment patterns
package light_display_pkg;

   localparam logic MODE_GREEN = 1'b0;
   localparam logic MODE_RED   = 1'b1;

   // Bit order {dp,g,f,e,d,c,b,a}, 1 = segment lit
   localparam logic [7:0] SEG_0     = 8'h3F;
   localparam logic [7:0] SEG_1     = 8'h06;
   localparam logic [7:0] SEG_2     = 8'h5B;
   localparam logic [7:0] SEG_3     = 8'h4F;
   localparam logic [7:0] SEG_4     = 8'h66;
   localparam logic [7:0] SEG_5     = 8'h6D;
   localparam logic [7:0] SEG_6     = 8'h7D;
   localparam logic [7:0] SEG_7     = 8'h07;
   localparam logic [7:0] SEG_8     = 8'h7F;
   localparam logic [7:0] SEG_9     = 8'h6F;
   localparam logic [7:0] SEG_BLANK = 8'h00;

endpackage

// File: rtl/light_display_seg7_decode.sv
// rtl/light_display_seg7_decode.sv - combinational digit to active-high 7-segment pattern
module seg7_decode
   import light_display_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   output logic [7:0] pattern
);

   always_comb begin
      pattern = SEG_BLANK;
      if (!blank) begin
         case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/light_display.sv
// rtl/light_display.sv - lamp drive, warning blink and 2-digit multiplexed countdown display
module light_display
   import light_display_pkg::*;
#(
   parameter logic [15:0] SCAN_DIV   = 16'd50000,
   parameter logic [23:0] BLINK_DIV  = 24'd6250000,
   parameter logic [3:0]  WARN_TIME  = 4'd3,
   parameter logic        ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mode,
   input  logic [3:0] red_cnt,
   input  logic [3:0] green_cnt,
   output logic       led_red,
   output logic       led_yellow,
   output logic       led_green,
   output logic [7:0] seg,
   output logic [1:0] an
);

   localparam logic [7:0] SEG_OFF = {8{ACTIVE_LOW}};
   localparam logic [1:0] AN_OFF  = {2{ACTIVE_LOW}};

   logic        mode_q, mode_d;
   logic [3:0]  red_q, red_d;
   logic [3:0]  green_q, green_d;
   logic [15:0] scan_cnt_q, scan_cnt_d;
   logic        digit_sel_q, digit_sel_d;
   logic [23:0] blink_cnt_q, blink_cnt_d;
   logic        blink_ph_q, blink_ph_d;
   logic        led_red_q, led_red_d;
   logic        led_yellow_q, led_yellow_d;
   logic        led_green_q, led_green_d;
   logic [7:0]  seg_q, seg_d;
   logic [1:0]  an_q, an_d;

   logic [3:0]  value;
   logic        tens;
   logic [3:0]  ones;
   logic        warn;
   logic [3:0]  dec_digit;
   logic        dec_blank;
   logic [7:0]  dec_pattern;

   always_comb begin
      value     = (mode_q == MODE_RED) ? red_q : green_q;
      tens      = (value >= 4'd10);
      ones      = tens ? (value - 4'd10) : value;
      warn      = (mode_q == MODE_GREEN) && (green_q <= WARN_TIME);
      // Tens slot keeps its enable but shows nothing when the value is single-digit
      dec_digit = digit_sel_q ? {3'b000, tens} : ones;
      dec_blank = digit_sel_q & ~tens;
   end

   seg7_decode u_seg7_decode (
      .digit   (dec_digit),
      .blank   (dec_blank),
      .pattern (dec_pattern)
   );

   always_comb begin
      mode_d       = mode;
      red_d        = red_cnt;
      green_d      = green_cnt;

      scan_cnt_d   = scan_cnt_q + 16'd1;
      digit_sel_d  = digit_sel_q;
      if (scan_cnt_q == SCAN_DIV - 16'd1) begin
         scan_cnt_d  = 16'd0;
         digit_sel_d = ~digit_sel_q;
      end

      // Outside a warning window the blink is parked so the next window opens on a full on-phase
      blink_cnt_d  = 24'd0;
      blink_ph_d   = 1'b1;
      if (warn) begin
         blink_cnt_d = blink_cnt_q + 24'd1;
         blink_ph_d  = blink_ph_q;
         if (blink_cnt_q == BLINK_DIV - 24'd1) begin
            blink_cnt_d = 24'd0;
            blink_ph_d  = ~blink_ph_q;
         end
      end

      led_red_d    = 1'b0;
      led_yellow_d = 1'b0;
      led_green_d  = 1'b0;
      if (mode_q == MODE_RED) begin
         led_red_d = 1'b1;
      end else if (warn) begin
         led_yellow_d = 1'b1;
         led_green_d  = blink_ph_q;
      end else begin
         led_green_d = 1'b1;
      end

      seg_d = dec_pattern ^ SEG_OFF;
      an_d  = (digit_sel_q ? 2'b10 : 2'b01) ^ AN_OFF;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q       <= 1'b0;
         red_q        <= 4'd0;
         green_q      <= 4'd0;
         scan_cnt_q   <= 16'd0;
         digit_sel_q  <= 1'b0;
         blink_cnt_q  <= 24'd0;
         blink_ph_q   <= 1'b1;
         led_red_q    <= 1'b0;
         led_yellow_q <= 1'b0;
         led_green_q  <= 1'b0;
         seg_q        <= SEG_OFF;
         an_q         <= AN_OFF;
      end else begin
         mode_q       <= mode_d;
         red_q        <= red_d;
         green_q      <= green_d;
         scan_cnt_q   <= scan_cnt_d;
         digit_sel_q  <= digit_sel_d;
         blink_cnt_q  <= blink_cnt_d;
         blink_ph_q   <= blink_ph_d;
         led_red_q    <= led_red_d;
         led_yellow_q <= led_yellow_d;
         led_green_q  <= led_green_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
      end
   end

   assign led_red    = led_red_q;
   assign led_yellow = led_yellow_q;
   assign led_green  = led_green_q;
   assign seg        = seg_q;
   assign an         = an_q;

endmodule
